jk_bank_arbiter: RTL

//   Round-robin arbiter that shares one bank of WIDTH JK flip-flops between NREQ requesters.

---
 rtl/jk_bank_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one bank of WIDTH JK flip-flops between NREQ requesters.
// Optional saturating contention counter is enabled by defining JK_ARB_CONTENTION_CNT_EN.

module jk_bank_arbiter_cell (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (en) begin
            unique case ({j, k})
                2'b00: q <= q;
                2'b01: q <= 1'b0;
                2'b10: q <= 1'b1;
                2'b11: q <= ~q;
            endcase
        end
    end
endmodule

module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      j,
    input  logic [NREQ-1:0]      k,
    input  logic [NREQ*IDXW-1:0] idx,
`ifdef JK_ARB_CONTENTION_CNT_EN
    output logic [15:0]          contention_cnt,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 busy
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {IDLE, APPLY} state_t;

    typedef struct packed {
        logic            j;
        logic            k;
        logic [IDXW-1:0] idx;
    } jk_cmd_t;

    state_t         state;
    jk_cmd_t        cmd;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  sel;
    logic [PW-1:0]  sel_nxt;
    logic           found;
    logic [WIDTH-1:0] hit;

    // First requester at or after ptr, wrapping modulo NREQ (NREQ need not be a power of 2).
    always_comb begin
        int c;
        c     = 0;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            if (!found && req[c]) begin
                found = 1'b1;
                sel   = PW'(c);
            end
        end
        sel_nxt = (int'(sel) == NREQ - 1) ? '0 : sel + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cmd   <= '0;
            ptr   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        cmd.j   <= j[sel];
                        cmd.k   <= k[sel];
                        cmd.idx <= idx[int'(sel)*IDXW +: IDXW];
                        gnt     <= NREQ'(1) << sel;
                        busy    <= 1'b1;
                        ptr     <= sel_nxt;
                        state   <= APPLY;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                APPLY: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Out-of-range indices match no cell, so the bank simply holds.
    always_comb begin
        hit = '0;
        for (int b = 0; b < WIDTH; b++)
            hit[b] = (state == APPLY) && (int'(cmd.idx) == b);
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        jk_bank_arbiter_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (hit[b]),
            .j     (cmd.j),
            .k     (cmd.k),
            .q     (q[b])
        );
    end

`ifdef JK_ARB_CONTENTION_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            contention_cnt <= '0;
        else if (state == IDLE && $countones(req) > 1 && contention_cnt != 16'hFFFF)
            contention_cnt <= contention_cnt + 16'd1;
    end
`else
    // No contention tracking in this build.
`endif

endmodule
